// File: rtl/cell_marker.sv
// cell_marker
// Converts a committed board cell index (row [5:3], column [2:0]) into the
// pixel origin of that cell and draws a rectangular outline around it on the
// VGA pixel stream. Cell requests use a valid/ready handshake. A request is
// only made visible at the start of vertical blank, so the outline never
// tears mid-frame.
//
// Ports:
//   clk, rst                      pixel clock, asynchronous active-high reset
//   cell_idx, cell_valid          requested cell and its strobe
//   cell_ready                    high while a new request can be accepted
//   marker_en                     outline visible when high
//   hcount_in .. rgb_in           upstream VGA timing and pixel
//   hcount_out .. rgb_out         the same stream delayed 1 clk, outline overlaid
//   cell_x_out, cell_y_out        committed cell origin in pixels
//   marker_active                 a cell has been committed since reset
module cell_marker #(
    parameter int          BOARD_X0   = 256,
    parameter int          BOARD_Y0   = 128,
    parameter int          CELL_SIZE  = 48,
    parameter int          BORDER     = 2,
    parameter logic [11:0] MARK_COLOR = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cell_idx,
    input  logic        cell_valid,
    output logic        cell_ready,
    input  logic        marker_en,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [11:0] cell_x_out,
    output logic [11:0] cell_y_out,
    output logic        marker_active
);

    localparam logic [11:0] ORIGIN_X_C = 12'(BOARD_X0);
    localparam logic [11:0] ORIGIN_Y_C = 12'(BOARD_Y0);
    localparam logic [11:0] LAST_C     = 12'(CELL_SIZE - 1);
    localparam logic [11:0] BORDER_C   = 12'(BORDER);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CALC       = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

    state_t      state_r;
    logic [5:0]  idx_r;
    logic [11:0] pend_x_r;
    logic [11:0] pend_y_r;
    logic        vblnk_prev_r;

    logic [11:0] h_s;
    logic [11:0] v_s;
    logic        in_box_s;
    logic        on_edge_s;
    logic        overlay_s;

    // Board offset of a row/column: n*48 is a pair of shifts, other sizes multiply.
    function automatic logic [11:0] cell_offset(input logic [2:0] n);
        logic [11:0] wide;
        wide = {9'd0, n};
        if (CELL_SIZE == 48) begin
            cell_offset = (wide << 5) + (wide << 4);
        end else begin
            cell_offset = wide * 12'(CELL_SIZE);
        end
    endfunction

    // Request handshake, origin computation and commit at vertical-blank start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= 6'd0;
            pend_x_r      <= 12'd0;
            pend_y_r      <= 12'd0;
            vblnk_prev_r  <= 1'b0;
            cell_ready    <= 1'b1;
            cell_x_out    <= 12'd0;
            cell_y_out    <= 12'd0;
            marker_active <= 1'b0;
        end else begin
            vblnk_prev_r <= vblnk_in;
            case (state_r)
                IDLE: begin
                    if (cell_valid && cell_ready) begin
                        idx_r      <= cell_idx;
                        cell_ready <= 1'b0;
                        state_r    <= CALC;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                CALC: begin
                    pend_x_r <= ORIGIN_X_C + cell_offset(idx_r[2:0]);
                    pend_y_r <= ORIGIN_Y_C + cell_offset(idx_r[5:3]);
                    state_r  <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    // Only a genuine low-to-high vblank transition commits; a
                    // vblank already in progress on entry is skipped.
                    if (vblnk_in && !vblnk_prev_r) begin
                        cell_x_out    <= pend_x_r;
                        cell_y_out    <= pend_y_r;
                        marker_active <= 1'b1;
                        cell_ready    <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        state_r       <= WAIT_FRAME;
                    end
                end
                default: begin
                    cell_ready <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // Outline hit test against the committed cell box.
    always_comb begin
        h_s       = {1'b0, hcount_in};
        v_s       = {1'b0, vcount_in};
        in_box_s  = (h_s >= cell_x_out) && (h_s <= cell_x_out + LAST_C) &&
                    (v_s >= cell_y_out) && (v_s <= cell_y_out + LAST_C);
        on_edge_s = (h_s < cell_x_out + BORDER_C) ||
                    (h_s > cell_x_out + LAST_C - BORDER_C) ||
                    (v_s < cell_y_out + BORDER_C) ||
                    (v_s > cell_y_out + LAST_C - BORDER_C);
        overlay_s = marker_en && marker_active && !hblnk_in && !vblnk_in &&
                    in_box_s && on_edge_s;
    end

    // One-clock pipeline stage for the timing signals and the overlaid pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            if (overlay_s) begin
                rgb_out <= MARK_COLOR;
            end else begin
                rgb_out <= rgb_in;
            end
        end
    end

endmodule

// File: doc/cell_marker.md
# cell_marker

Inverse of the cursor-to-cell decoder: takes a 6-bit board cell index (row in [5:3], column in [2:0]) and converts it back to the pixel origin of that cell on the 8×8 board (origin 256,128; 48-px cells). It then overlays a rectangular outline around that cell on the VGA pixel stream. The block sits in the VGA draw chain after the board renderer and before the mouse cursor overlay. Cell updates are accepted through a valid/ready handshake and committed only at vertical-blank start, so the marker never tears mid-frame.

## Interface
- BOARD_X0, 256: pixel x of board column 0
- BOARD_Y0, 128: pixel y of board row 0
- CELL_SIZE, 48: cell edge in pixels
- BORDER, 2: outline thickness in pixels
- MARK_COLOR, 12'hF00: outline RGB444 color
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- cell_idx  in  6  requested cell, [5:3] row, [2:0] column
- cell_valid  in  1  request strobe
- cell_ready  out  1  block can accept a request
- marker_en  in  1  outline visible when high
- hcount_in, vcount_in  in  11 each  VGA counters
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing
- rgb_in  in  12  upstream pixel
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  same widths  timing delayed 1 clk
- rgb_out  out  12  pixel after overlay
- cell_x_out, cell_y_out  out  12 each  committed cell origin in pixels
- marker_active  out  1  a cell has been committed since reset

## Operation
- FSM states: IDLE, CALC, WAIT_FRAME.
- IDLE: cell_ready=1. When cell_valid & cell_ready at a clock edge, latch cell_idx and go to CALC.
- CALC (1 clk): compute pend_x = BOARD_X0 + col*CELL_SIZE and pend_y = BOARD_Y0 + row*CELL_SIZE in 12-bit unsigned; then go to WAIT_FRAME. With the default CELL_SIZE, the multiply is implemented as (n<<5)+(n<<4). The maximum result is 592+47=639, so there is no overflow.
- WAIT_FRAME: cell_ready=0. Detect the vblnk_in rising edge (vblnk_in=1 while vblnk_prev=0). On that edge:
  - active_x/y <= pend_x/y
  - marker_active <= 1
  - state <= IDLE
- Entering WAIT_FRAME while vblnk_in is already high does not commit. The block waits for the next rising edge.
- cell_valid while cell_ready=0 is ignored. The requester must hold the request. No queueing.
- cell_x_out/cell_y_out = active_x/active_y. They change only at commit.
- Overlay condition: marker_en & marker_active & !hblnk_in & !vblnk_in, with the pixel inside [x0, x0+CELL_SIZE-1] × [y0, y0+CELL_SIZE-1]. The pixel must also be within BORDER pixels of any edge of that box, i.e. hcount < x0+BORDER, or hcount > x0+CELL_SIZE-1-BORDER, or the same tests on vcount.
  - Condition true: rgb_out <= MARK_COLOR.
  - Condition false: rgb_out <= rgb_in.
- marker_en=0: pure pass-through. Committed position is retained.

## Timing
- Reset values:
  - state=IDLE, cell_ready=1, marker_active=0
  - cell_x_out=0, cell_y_out=0, rgb_out=0
  - all timing outputs 0, vblnk_prev=0
- Overlay/pass-through latency: exactly 1 clk for rgb and all timing signals (registered outputs).
- Request acceptance at edge N:
  - state=CALC during cycle N..N+1
  - WAIT_FRAME from edge N+1
  - cell_ready=0 from edge N
- Commit: at the edge that samples the vblnk_in rising edge. cell_x_out, cell_y_out and marker_active update at that edge. cell_ready=1 in the same cycle (state IDLE).
- Back-to-back request: one may be accepted at the first edge after commit. Maximum throughput is one cell per frame.
- Async rst mid-WAIT_FRAME: the pending request is discarded, marker_active clears, and the next frame is pure pass-through.

## Test plan
- Reset, then cell_idx=6'o00 accepted, wait for vblank:
  - cell_x_out=256, cell_y_out=128, marker_active=1
  - Next frame: pixel (256,128)→12'hF00; (257,150)→F00; (258,130)→rgb_in; (303,175)→F00.
- cell_idx=6'o77:
  - cell_x_out=592, cell_y_out=464
  - Pixel (639,511)→F00; pixel (591,470)→rgb_in.
- Request during active video:
  - cell_ready drops the edge after acceptance.
  - A second cell_valid (idx 6'o12) before vblank is ignored.
  - The first request commits at the vblnk rise, and cell_ready returns high in the same cycle.
- Request accepted while vblnk_in already high: no commit until the next frame's vblnk rise. Old position stays drawn.
- marker_en=0 and blanking pixels: rgb_out equals rgb_in delayed 1 clk for all pixels. Timing outputs are always delayed exactly 1 clk.
- Assert rst in WAIT_FRAME: cell_ready=1, marker_active=0, cell_x_out=0 immediately; no overlay in subsequent frames.
